// File: rtl/cnt_seq_pkg.sv
// Shared types and constants for the count_zeros front-end controller.
// Holds the FSM encoding and the serial bit-select helper.
package cnt_seq_pkg;

  localparam int FRAME_W  = 8;
  localparam int ZERO_W   = 4;
  localparam int CNT_BITS = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_WAIT,
    S_RESP
  } state_e;

  function automatic logic frame_bit(
    input logic [FRAME_W-1:0]  f,
    input logic [CNT_BITS-1:0] k,
    input logic                msb_first
  );
    logic [CNT_BITS-1:0] sel;
    sel = msb_first ? (CNT_BITS'(FRAME_W - 1) - k) : k;
    return f[sel];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, first asserted request wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int i;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    i     = 0;
    for (int k = 0; k < NREQ; k++) begin
      i = (int'(ptr) + k) % NREQ;
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Arbitrates requester frames and streams each one serially into the
// shared count_zeros checker, returning the tagged result.
module cnt_seq_ctrl #(
  parameter int NREQ      = 2,
  parameter int IDW       = 1,
  parameter int TIMEOUT   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_zeros,
  output logic              rsp_legal,
  output logic              rsp_error,
  output logic              busy,
  output logic              cnt_reset,
  output logic              cnt_read,
  output logic              cnt_data,
  input  logic [3:0]        cnt_zeros,
  input  logic              cnt_is_legal,
  input  logic              cnt_data_ready
);
  import cnt_seq_pkg::*;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e                state_q, state_d;
  logic [FRAME_W-1:0]    frame_q, frame_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [CNT_BITS-1:0]   bit_q, bit_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [ZERO_W-1:0]     zeros_q, zeros_d;
  logic                  legal_q, legal_d;
  logic                  error_q, error_d;

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       arb_gnt;
  logic [IDW-1:0]        arb_idx;
  logic                  arb_any;

  // Grants only in IDLE and never while reset is asserted.
  assign arb_req = req_valid & {NREQ{(state_q == S_IDLE) && !reset}};

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    bit_d   = bit_q;
    tcnt_d  = tcnt_q;
    zeros_d = zeros_q;
    legal_d = legal_q;
    error_d = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          state_d = S_CLEAR;
          frame_d = req_data[8*int'(arb_idx) +: 8];
          id_d    = arb_idx;
          ptr_d   = (int'(arb_idx) == NREQ - 1) ? '0
                                                : arb_idx + IDW'(1);
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
        bit_d   = '0;
      end
      S_SHIFT: begin
        bit_d = bit_q + CNT_BITS'(1);
        if (bit_q == CNT_BITS'(FRAME_W - 1)) begin
          state_d = S_WAIT;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (cnt_data_ready) begin
          state_d = S_RESP;
          zeros_d = cnt_zeros;
          legal_d = cnt_is_legal;
          error_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          zeros_d = '0;
          legal_d = 1'b0;
          error_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      bit_q   <= '0;
      tcnt_q  <= '0;
      zeros_q <= '0;
      legal_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      bit_q   <= bit_d;
      tcnt_q  <= tcnt_d;
      zeros_q <= zeros_d;
      legal_q <= legal_d;
      error_q <= error_d;
    end
  end

  assign req_ready = arb_gnt;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_zeros = zeros_q;
  assign rsp_legal = legal_q;
  assign rsp_error = error_q;
  assign busy      = (state_q != S_IDLE);
  assign cnt_reset = reset | (state_q == S_CLEAR);
  assign cnt_read  = (state_q == S_SHIFT);
  assign cnt_data  = cnt_read &
                     frame_bit(frame_q, bit_q, MSB_FIRST != 0);

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: directed vector table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_cnt_seq_ctrl;

  localparam int NREQ    = 2;
  localparam int IDW     = 1;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_zeros;
  logic              rsp_legal;
  logic              rsp_error;
  logic              busy;
  logic              cnt_reset;
  logic              cnt_read;
  logic              cnt_data;
  logic [3:0]        cnt_zeros = '0;
  logic              cnt_is_legal = 1'b0;
  logic              cnt_data_ready = 1'b0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(
    .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .MSB_FIRST(1)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_zeros(rsp_zeros), .rsp_legal(rsp_legal), .rsp_error(rsp_error),
    .busy(busy), .cnt_reset(cnt_reset), .cnt_read(cnt_read),
    .cnt_data(cnt_data), .cnt_zeros(cnt_zeros),
    .cnt_is_legal(cnt_is_legal), .cnt_data_ready(cnt_data_ready)
  );

  // Checker model: collects bits, flags an illegal frame as soon as a
  // second zero run starts (early ready), otherwise ready after bit 8.
  bit         ck_never = 1'b0;
  logic [7:0] ck_byte = '0;
  int         ck_n = 0;
  int         ck_ph = 0;
  logic       ck_bad = 1'b0;

  function automatic logic f_bad(input logic b, input int ph, input logic d);
    return b || (!d && ph == 2);
  endfunction

  function automatic int f_ph(input int ph, input logic d);
    if (!d) return (ph == 2) ? 2 : 1;
    return (ph == 1) ? 2 : ph;
  endfunction

  always @(posedge clk) begin
    if (cnt_reset) begin
      ck_n <= 0; ck_ph <= 0; ck_bad <= 1'b0; ck_byte <= '0;
      cnt_data_ready <= 1'b0; cnt_zeros <= '0; cnt_is_legal <= 1'b0;
    end else if (cnt_read && ck_n < 8) begin
      ck_byte <= {ck_byte[6:0], cnt_data};
      ck_n    <= ck_n + 1;
      ck_ph   <= f_ph(ck_ph, cnt_data);
      ck_bad  <= f_bad(ck_bad, ck_ph, cnt_data);
      if (!ck_never && (f_bad(ck_bad, ck_ph, cnt_data) || ck_n == 7)) begin
        cnt_data_ready <= 1'b1;
        cnt_zeros <= f_bad(ck_bad, ck_ph, cnt_data) ? 4'd0 :
                     4'(8 - $countones({ck_byte[6:0], cnt_data}));
        cnt_is_legal <= !f_bad(ck_bad, ck_ph, cnt_data);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: zeros must form one contiguous run to be legal.
  function automatic void ref_frame(input logic [7:0] f,
                                    output logic [3:0] z, output logic l);
    int runs = 0;
    int zc = 0;
    logic prev = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      if (!f[i]) begin
        zc++;
        if (prev) runs++;
      end
      prev = f[i];
    end
    l = (runs <= 1);
    z = l ? 4'(zc) : 4'd0;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt_read", cnt_read, 0);
    chk("rst_cnt_data", cnt_data, 0);
    chk("rst_cnt_reset", cnt_reset, 1);
    chk("rst_rsp_fields", {rsp_id, rsp_zeros, rsp_legal, rsp_error}, 0);
    tick();
    reset = 1'b0; req_valid = '0;
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_one(input int r, input logic [7:0] f,
                         input logic [3:0] ez, input logic el,
                         input logic ee, input int elat, input string nm);
    int k;
    int nrd;
    logic [7:0] sh;
    bit done;
    req_valid = '0; req_valid[r] = 1'b1;
    req_data[8*r +: 8] = f; rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_gnt"}, req_ready, 32'(1) << r);
    tick();
    req_valid = '0;
    k = 1; nrd = 0; sh = '0; done = 1'b0;
    while (!done && k <= 40) begin
      @(negedge clk);
      if (k == 1) chk({nm, "_clr"}, cnt_reset, 1);
      if (cnt_read) begin
        nrd++;
        sh = {sh[6:0], cnt_data};
      end
      if (rsp_valid) begin
        done = 1'b1;
        chk({nm, "_lat"}, k, elat);
        chk({nm, "_rsp"}, {rsp_id, rsp_zeros, rsp_legal, rsp_error},
            {IDW'(r), ez, el, ee});
      end else begin
        k++;
      end
    end
    if (!done) chk({nm, "_no_rsp"}, 0, 1);
    chk({nm, "_nread"}, nrd, 8);
    chk({nm, "_bits"}, sh, f);
    tick();
  endtask

  typedef struct {
    logic [7:0] f;
    logic [3:0] z;
    logic       l;
  } vec_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [7:0]     f;
    logic [3:0]     z;
    logic           l;
    logic           e;
  } exp_t;

  initial begin
    vec_t tbl[8];
    exp_t q[$];
    logic [3:0] hz;
    logic hl;
    bit ok;
    bit seen;

    tbl[0] = '{8'b1100_0011, 4'd4, 1'b1};
    tbl[1] = '{8'b1010_0000, 4'd0, 1'b0};
    tbl[2] = '{8'hFF, 4'd0, 1'b1};
    tbl[3] = '{8'h00, 4'd8, 1'b1};
    tbl[4] = '{8'h0F, 4'd4, 1'b1};
    tbl[5] = '{8'h81, 4'd6, 1'b1};
    tbl[6] = '{8'h7E, 4'd0, 1'b0};
    tbl[7] = '{8'hE7, 4'd2, 1'b1};

    do_reset();
    for (int i = 0; i < 8; i++)
      run_one(i % 2, tbl[i].f, tbl[i].z, tbl[i].l, 1'b0, 11,
              $sformatf("vec%0d", i));

    ck_never = 1'b1;
    run_one(0, 8'hC3, 4'd0, 1'b0, 1'b1, 10 + TIMEOUT, "timeout");
    ck_never = 1'b0;

    // Back-pressure: response held, everyone else stalled.
    req_valid = 2'b01; req_data[7:0] = 8'h0F; rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_gnt", req_ready, 2'b01);
    tick();
    req_valid = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("bp_rsp_seen", ok, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_hold", {rsp_valid, rsp_id, rsp_zeros, rsp_legal, rsp_error},
          {1'b1, 1'b0, 4'd4, 1'b1, 1'b0});
      chk("bp_no_gnt", req_ready, 0);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_next_gnt", req_ready, 2'b10);
    do_reset();

    // Simultaneous requesters alternate after reset.
    req_valid = 2'b11; req_data = {8'h00, 8'hFF}; rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        ok = (req_ready != 0);
      end
      chk("alt_gnt", req_ready, (n % 2) ? 2'b10 : 2'b01);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        ok = rsp_valid;
      end
      chk("alt_rsp", {rsp_id, rsp_zeros, rsp_legal},
          (n % 2) ? {1'b1, 4'd8, 1'b1} : {1'b0, 4'd0, 1'b1});
    end
    tick();
    do_reset();

    // Reset during SHIFT bit 3 drops the frame.
    req_valid = 2'b01; req_data[7:0] = 8'hC3; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("mid_shift", cnt_read, 1);
    reset = 1'b1;
    #1;
    chk("mid_cnt_reset", cnt_reset, 1);
    tick();
    @(negedge clk);
    chk("mid_idle", {busy, cnt_read, cnt_reset}, 3'b001);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("mid_no_rsp", seen, 0);
    do_reset();

    // Randomized run against the transaction-level model.
    begin
      int mptr = 0;
      bit infl = 1'b0;
      int age = 0;
      logic [NREQ-1:0] eg;
      int ei;
      exp_t e;
      for (int c = 0; c < 3000; c++) begin
        tick();
        req_valid = NREQ'($urandom);
        req_data  = 16'($urandom);
        rsp_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        eg = '0; ei = 0;
        if (!infl)
          for (int k = 0; k < NREQ; k++)
            if (eg == 0 && req_valid[(mptr + k) % NREQ]) begin
              ei = (mptr + k) % NREQ;
              eg[ei] = 1'b1;
            end
        chk("rnd_gnt", req_ready, eg);
        chk("rnd_busy", busy, infl);
        if (!infl) chk("rnd_idle_rsp", rsp_valid, 0);
        if (infl && rsp_valid && rsp_ready) begin
          e = q.pop_front();
          chk("rnd_rsp", {rsp_id, rsp_zeros, rsp_legal, rsp_error},
              {e.id, e.z, e.l, e.e});
          chk("rnd_bits", ck_byte, e.f);
          infl = 1'b0;
        end else if (eg != 0) begin
          e.id = IDW'(ei);
          e.f  = req_data[8*ei +: 8];
          ck_never = ($urandom_range(7) == 0);
          ref_frame(e.f, hz, hl);
          e.z = ck_never ? 4'd0 : hz;
          e.l = ck_never ? 1'b0 : hl;
          e.e = ck_never;
          q.push_back(e);
          mptr = (ei + 1) % NREQ;
          infl = 1'b1;
          age = 0;
        end
        if (infl) age++;
        if (age > 60) begin
          chk("rnd_stall", 0, 1);
          break;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
